// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data requests onto one memory port, one transaction at a time.
// Define ROUND_ROBIN_EN to alternate grants when both requesters are pending.
module mem_port_arbiter #(
   parameter int XLEN = 32,
   parameter int AW   = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              i_valid,
   input  logic [AW-1:0]     i_addr,
   output logic              i_ready,
   output logic [XLEN-1:0]   i_rdata,
   input  logic              d_valid,
   input  logic              d_store,
   input  logic [AW-1:0]     d_addr,
   input  logic [XLEN-1:0]   d_wdata,
   input  logic [XLEN/8-1:0] d_wstrb,
   output logic              d_ready,
   output logic [XLEN-1:0]   d_rdata,
   input  logic              flush,
   output logic              mem_valid,
   output logic              mem_instr,
   output logic [AW-1:0]     mem_addr,
   output logic [XLEN-1:0]   mem_wdata,
   output logic [XLEN/8-1:0] mem_wstrb,
   input  logic              mem_ready,
   input  logic [XLEN-1:0]   mem_rdata,
   output logic              protocol_err
);

   typedef enum logic [1:0] {S_IDLE, S_BUSY_I, S_BUSY_D} state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_i_pend;
   logic [AW-1:0]       r_i_addr;
   logic                r_d_pend;
   logic                r_d_store;
   logic [AW-1:0]       r_d_addr;
   logic [XLEN-1:0]     r_d_wdata;
   logic [XLEN/8-1:0]   r_d_wstrb;
   logic                r_squash;
   logic                r_err;
   logic                r_mem_valid;
   logic                r_mem_instr;
   logic [AW-1:0]       r_mem_addr;
   logic [XLEN-1:0]     r_mem_wdata;
   logic [XLEN/8-1:0]   r_mem_wstrb;

   logic                w_done;
   logic                w_arb;
   logic                w_i_err;
   logic                w_d_err;
   logic                w_i_cap;
   logic                w_d_cap;
   logic                w_i_pend;
   logic                w_d_pend;
   logic [AW-1:0]       w_i_addr;
   logic                w_d_store;
   logic [AW-1:0]       w_d_addr;
   logic [XLEN-1:0]     w_d_wdata;
   logic [XLEN/8-1:0]   w_d_wstrb;
   logic                w_pick_i;
   logic                w_grant_i;
   logic                w_grant_d;

   assign w_done = mem_ready && (r_state != S_IDLE);
   assign w_arb  = (r_state == S_IDLE) || w_done;

   // A fetch after a flush targets the new PC, so it is legal even while
   // the squashed fetch is still outstanding.
   assign w_i_err = i_valid && (r_state == S_BUSY_I) && !mem_ready
                    && !r_squash && !flush;
   assign w_d_err = d_valid && (r_state == S_BUSY_D) && !mem_ready;

   assign w_i_cap   = i_valid && !w_i_err;
   assign w_d_cap   = d_valid && !w_d_err;
   assign w_i_pend  = (r_i_pend && !flush) || w_i_cap;
   assign w_d_pend  = r_d_pend || w_d_cap;
   assign w_i_addr  = w_i_cap ? i_addr  : r_i_addr;
   assign w_d_store = w_d_cap ? d_store : r_d_store;
   assign w_d_addr  = w_d_cap ? d_addr  : r_d_addr;
   assign w_d_wdata = w_d_cap ? d_wdata : r_d_wdata;
   assign w_d_wstrb = w_d_cap ? d_wstrb : r_d_wstrb;

`ifdef ROUND_ROBIN_EN
   logic r_last_d;

   assign w_pick_i = w_i_pend && (!w_d_pend || r_last_d);

   always_ff @(posedge clock) begin
      if (reset) begin
         r_last_d <= 1'b0;
      end else if (w_grant_i || w_grant_d) begin
         r_last_d <= w_grant_d;
      end
   end
`else
   assign w_pick_i = w_i_pend && !w_d_pend;
`endif

   assign w_grant_i = w_arb && w_pick_i;
   assign w_grant_d = w_arb && w_d_pend && !w_pick_i;

   always_comb begin
      w_state_nxt = r_state;
      if (w_arb) begin
         if (w_grant_d) begin
            w_state_nxt = S_BUSY_D;
         end else if (w_grant_i) begin
            w_state_nxt = S_BUSY_I;
         end else begin
            w_state_nxt = S_IDLE;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_i_pend    <= 1'b0;
         r_i_addr    <= '0;
         r_d_pend    <= 1'b0;
         r_d_store   <= 1'b0;
         r_d_addr    <= '0;
         r_d_wdata   <= '0;
         r_d_wstrb   <= '0;
         r_squash    <= 1'b0;
         r_err       <= 1'b0;
         r_mem_valid <= 1'b0;
         r_mem_instr <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_mem_wstrb <= '0;
      end else begin
         r_i_pend    <= w_i_pend && !w_grant_i;
         r_i_addr    <= w_i_addr;
         r_d_pend    <= w_d_pend && !w_grant_d;
         r_d_store   <= w_d_store;
         r_d_addr    <= w_d_addr;
         r_d_wdata   <= w_d_wdata;
         r_d_wstrb   <= w_d_wstrb;
         r_err       <= r_err || w_i_err || w_d_err;
         r_mem_valid <= w_grant_i || w_grant_d;
         if (w_done) begin
            r_squash <= 1'b0;
         end else if (flush && (r_state == S_BUSY_I)) begin
            r_squash <= 1'b1;
         end
         if (w_grant_d) begin
            r_mem_instr <= 1'b0;
            r_mem_addr  <= w_d_addr;
            r_mem_wdata <= w_d_wdata;
            r_mem_wstrb <= w_d_store ? w_d_wstrb : '0;
         end else if (w_grant_i) begin
            r_mem_instr <= 1'b1;
            r_mem_addr  <= w_i_addr;
            r_mem_wdata <= '0;
            r_mem_wstrb <= '0;
         end
      end
   end

   assign i_ready = mem_ready && (r_state == S_BUSY_I) && !r_squash && !flush;
   assign d_ready = mem_ready && (r_state == S_BUSY_D);
   assign i_rdata = mem_rdata;
   assign d_rdata = mem_rdata;

   assign mem_valid    = r_mem_valid;
   assign mem_instr    = r_mem_instr;
   assign mem_addr     = r_mem_addr;
   assign mem_wdata    = r_mem_wdata;
   assign mem_wstrb    = r_mem_wstrb;
   assign protocol_err = r_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed scenarios then random traffic
// against a transaction-level reference model.
module tb_mem_port_arbiter;
   localparam int XLEN = 32;
   localparam int AW   = 32;
   localparam int SW   = XLEN / 8;

   logic            clock = 1'b0;
   logic            reset = 1'b1;
   logic            i_valid = 1'b0;
   logic [AW-1:0]   i_addr = '0;
   logic            i_ready;
   logic [XLEN-1:0] i_rdata;
   logic            d_valid = 1'b0;
   logic            d_store = 1'b0;
   logic [AW-1:0]   d_addr = '0;
   logic [XLEN-1:0] d_wdata = '0;
   logic [SW-1:0]   d_wstrb = '0;
   logic            d_ready;
   logic [XLEN-1:0] d_rdata;
   logic            flush = 1'b0;
   logic            mem_valid;
   logic            mem_instr;
   logic [AW-1:0]   mem_addr;
   logic [XLEN-1:0] mem_wdata;
   logic [SW-1:0]   mem_wstrb;
   logic            mem_ready = 1'b0;
   logic [XLEN-1:0] mem_rdata = '0;
   logic            protocol_err;

   mem_port_arbiter #(.XLEN(XLEN), .AW(AW)) dut (
      .clock(clock), .reset(reset),
      .i_valid(i_valid), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
      .d_valid(d_valid), .d_store(d_store), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_wstrb(d_wstrb), .d_ready(d_ready), .d_rdata(d_rdata),
      .flush(flush),
      .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .protocol_err(protocol_err)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int total = 0;
   int bad = 0;
   bit mon_en = 0;

   typedef struct {
      int              c;
      logic            instr;
      logic [AW-1:0]   addr;
      logic [XLEN-1:0] wdata;
      logic [SW-1:0]   wstrb;
   } mem_exp_t;
   typedef struct {
      int              c;
      logic [XLEN-1:0] rdata;
   } rdy_exp_t;

   mem_exp_t q_mem[$];
   rdy_exp_t q_i[$];
   rdy_exp_t q_d[$];

   typedef enum {NONE, OWN_I, OWN_D} own_t;

   // Reference model: one pending request per side, one owner of the port.
   bit              m_pi = 0;
   logic [AW-1:0]   m_pi_addr = '0;
   bit              m_pd = 0;
   bit              m_pd_store = 0;
   logic [AW-1:0]   m_pd_addr = '0;
   logic [XLEN-1:0] m_pd_wdata = '0;
   logic [SW-1:0]   m_pd_wstrb = '0;
   own_t            m_own = NONE;
   bit              m_sq = 0;
   bit              m_last_d = 0;
   bit              m_err = 0;
   bit              m_err_vis = 0;
   int              m_rdy_at = 0;

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at cycle %0d: got %h want %h", name, cyc, act, exp);
      end
   endfunction

   function automatic void model_step(
      input bit rst, input bit iv, input logic [AW-1:0] ia,
      input bit dv, input bit ds, input logic [AW-1:0] da,
      input logic [XLEN-1:0] dw, input logic [SW-1:0] dst,
      input bit fl, input bit mr, input logic [XLEN-1:0] mrd);
      bit was_sq;
      bit in_i;
      bit in_d;
      bit pick_i;
      mem_exp_t e;
      rdy_exp_t r;
      m_err_vis = m_err;
      if (rst) begin
         m_pi = 0; m_pd = 0; m_own = NONE; m_sq = 0;
         m_last_d = 0; m_err = 0;
         return;
      end
      was_sq = m_sq;
      in_i = (m_own == OWN_I) && !mr;
      in_d = (m_own == OWN_D) && !mr;
      if (mr && m_own == OWN_I && !m_sq && !fl) begin
         r.c = cyc; r.rdata = mrd; q_i.push_back(r);
      end
      if (mr && m_own == OWN_D) begin
         r.c = cyc; r.rdata = mrd; q_d.push_back(r);
      end
      if (mr) begin
         m_own = NONE; m_sq = 0;
      end
      if (fl) begin
         m_pi = 0;
         if (m_own == OWN_I) m_sq = 1;
      end
      if (iv) begin
         if (in_i && !was_sq && !fl) m_err = 1;
         else begin m_pi = 1; m_pi_addr = ia; end
      end
      if (dv) begin
         if (in_d) m_err = 1;
         else begin
            m_pd = 1; m_pd_store = ds; m_pd_addr = da;
            m_pd_wdata = dw; m_pd_wstrb = dst;
         end
      end
      if (m_own == NONE && (m_pi || m_pd)) begin
`ifdef ROUND_ROBIN_EN
         pick_i = m_pi && (!m_pd || m_last_d);
`else
         pick_i = m_pi && !m_pd;
`endif
         e.c = cyc + 1;
         if (pick_i) begin
            e.instr = 1; e.addr = m_pi_addr; e.wdata = '0; e.wstrb = '0;
            m_own = OWN_I; m_pi = 0; m_last_d = 0;
         end else begin
            e.instr = 0; e.addr = m_pd_addr; e.wdata = m_pd_wdata;
            e.wstrb = m_pd_store ? m_pd_wstrb : '0;
            m_own = OWN_D; m_pd = 0; m_last_d = 1;
         end
         q_mem.push_back(e);
         m_rdy_at = cyc + 1 + int'($urandom_range(0, 3));
      end
   endfunction

   task automatic step(
      input bit rst, input bit iv, input logic [AW-1:0] ia,
      input bit dv, input bit ds, input logic [AW-1:0] da,
      input logic [XLEN-1:0] dw, input logic [SW-1:0] dst,
      input bit fl, input bit mr, input logic [XLEN-1:0] mrd);
      @(posedge clock);
      #1;
      reset = rst; i_valid = iv; i_addr = ia;
      d_valid = dv; d_store = ds; d_addr = da; d_wdata = dw; d_wstrb = dst;
      flush = fl; mem_ready = mr; mem_rdata = mrd;
      model_step(rst, iv, ia, dv, ds, da, dw, dst, fl, mr, mrd);
   endtask

   task automatic idle();
      step(0, 0, '0, 0, 0, '0, '0, '0, 0, 0, $urandom);
   endtask

   task automatic rdy(input logic [XLEN-1:0] d);
      step(0, 0, '0, 0, 0, '0, '0, '0, 0, 1, d);
   endtask

   always @(negedge clock) begin
      if (mon_en) begin
         chk("protocol_err", protocol_err, m_err_vis);
         if (mem_valid === 1'b1) begin
            if (q_mem.size() == 0) chk("mem_valid_spurious", mem_valid, 0);
            else begin
               mem_exp_t e;
               e = q_mem.pop_front();
               chk("mem_cycle", cyc, e.c);
               chk("mem_instr", mem_instr, e.instr);
               chk("mem_addr", mem_addr, e.addr);
               chk("mem_wdata", mem_wdata, e.wdata);
               chk("mem_wstrb", mem_wstrb, e.wstrb);
            end
         end else if (q_mem.size() != 0 && q_mem[0].c <= cyc) begin
            chk("mem_valid_missing", mem_valid, 1);
            void'(q_mem.pop_front());
         end
         if (i_ready === 1'b1) begin
            if (q_i.size() == 0) chk("i_ready_spurious", i_ready, 0);
            else begin
               rdy_exp_t r;
               r = q_i.pop_front();
               chk("i_ready_cycle", cyc, r.c);
               chk("i_rdata", i_rdata, r.rdata);
            end
         end else if (q_i.size() != 0 && q_i[0].c <= cyc) begin
            chk("i_ready_missing", i_ready, 1);
            void'(q_i.pop_front());
         end
         if (d_ready === 1'b1) begin
            if (q_d.size() == 0) chk("d_ready_spurious", d_ready, 0);
            else begin
               rdy_exp_t r;
               r = q_d.pop_front();
               chk("d_ready_cycle", cyc, r.c);
               chk("d_rdata", d_rdata, r.rdata);
            end
         end else if (q_d.size() != 0 && q_d[0].c <= cyc) begin
            chk("d_ready_missing", d_ready, 1);
            void'(q_d.pop_front());
         end
      end
   end

   initial begin
      bit iv, dv, ds, fl, mr;
      int guard;
      step(1, 0, '0, 0, 0, '0, '0, '0, 0, 0, '0);
      step(1, 0, '0, 0, 0, '0, '0, '0, 0, 0, '0);
      @(negedge clock);
      chk("rst_mem_valid", mem_valid, 0);
      chk("rst_i_ready", i_ready, 0);
      chk("rst_d_ready", d_ready, 0);
      chk("rst_protocol_err", protocol_err, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_mem_wstrb", mem_wstrb, 0);
      mon_en = 1;
      step(0, 0, '0, 0, 0, '0, '0, '0, 0, 0, '0);

      // fetch only
      step(0, 1, 32'h100, 0, 0, '0, '0, '0, 0, 0, '0);
      idle(); idle();
      rdy(32'h0000_0013);
      idle();
      // simultaneous fetch and store
      step(0, 1, 32'h200, 1, 1, 32'h8000, 32'hDEAD_BEEF, 4'hF, 0, 0, '0);
      idle();
      rdy(32'h1111_1111);
      idle();
      rdy(32'h2222_2222);
      idle();
      // flush of a pending fetch behind a load
      step(0, 0, '0, 1, 0, 32'h9000, 32'h5555_5555, 4'h3, 0, 0, '0);
      idle();
      step(0, 1, 32'h300, 0, 0, '0, '0, '0, 0, 0, '0);
      step(0, 0, '0, 0, 0, '0, '0, '0, 1, 0, '0);
      rdy(32'h3333_3333);
      idle(); idle();
      // flush of an in-flight fetch with new-PC fetch in the flush cycle
      step(0, 1, 32'h380, 0, 0, '0, '0, '0, 0, 0, '0);
      idle();
      step(0, 1, 32'h400, 0, 0, '0, '0, '0, 1, 0, '0);
      idle();
      rdy(32'h4444_4444);
      idle();
      rdy(32'h0000_0093);
      idle();
      // protocol error: second store while the first is in flight
      step(0, 0, '0, 1, 1, 32'hA000, 32'hCAFE_F00D, 4'h5, 0, 0, '0);
      idle();
      step(0, 0, '0, 1, 1, 32'hB000, 32'h0BAD_0BAD, 4'hA, 0, 0, '0);
      idle();
      rdy(32'h6666_6666);
      idle(); idle();
      // reset mid-transaction, then a late completion
      step(0, 0, '0, 1, 0, 32'hC000, '0, '0, 0, 0, '0);
      idle();
      step(1, 0, '0, 0, 0, '0, '0, '0, 0, 0, '0);
      rdy(32'h7777_7777);
      idle();
      step(0, 1, 32'hD000, 0, 0, '0, '0, '0, 0, 0, '0);
      idle();
      rdy(32'h8888_8888);
      idle();

      for (int n = 0; n < 3000; n++) begin
         fl = ($urandom_range(0, 99) < 8);
         if (m_own != NONE) mr = (cyc + 1 >= m_rdy_at);
         else mr = ($urandom_range(0, 99) < 10);
         iv = ($urandom_range(0, 99) < 30);
         if (iv && m_own == OWN_I && !m_sq && !mr && !fl)
            iv = ($urandom_range(0, 99) < 3);
         dv = ($urandom_range(0, 99) < 30);
         if (dv && m_own == OWN_D && !mr)
            dv = ($urandom_range(0, 99) < 3);
         ds = $urandom_range(0, 1);
         step(0, iv, $urandom, dv, ds, $urandom, $urandom,
              4'($urandom_range(0, 15)), fl, mr, $urandom);
      end

      guard = 0;
      while ((m_own != NONE || m_pi || m_pd) && guard < 100) begin
         mr = (m_own != NONE) && (cyc + 1 >= m_rdy_at);
         step(0, 0, '0, 0, 0, '0, '0, '0, 0, mr, $urandom);
         guard++;
      end
      chk("drain_timeout", (guard < 100), 1);
      idle(); idle(); idle();
      @(negedge clock);
      #1;
      mon_en = 0;
      chk("q_mem_left", q_mem.size(), 0);
      chk("q_i_left", q_i.size(), 0);
      chk("q_d_left", q_d.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single memory/storebuffer port between instruction fetch (I) and execute-stage load/store/fence (D) requesters.
- Holds one pending request per requester and issues exactly one outstanding transaction downstream.
- Routes each completion pulse back to the requester that owns it.
- Sits between the fetch/execute stages and the storebuffer.

Parameters:
XLEN, 32, data width
AW, 32, address width

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-high reset
i_valid  in  1  fetch request pulse
i_addr  in  AW  fetch address
i_ready  out  1  fetch completion pulse
i_rdata  out  XLEN  fetch read data
d_valid  in  1  data request pulse
d_store  in  1  1=store, 0=load/fence
d_addr  in  AW  data address
d_wdata  in  XLEN  store data
d_wstrb  in  XLEN/8  store byte enables
d_ready  out  1  data completion pulse
d_rdata  out  XLEN  load data
flush  in  1  trap/mret/clear; cancels fetch traffic
mem_valid  out  1  downstream request pulse
mem_instr  out  1  1=fetch transaction
mem_addr  out  AW  downstream address
mem_wdata  out  XLEN  downstream store data
mem_wstrb  out  XLEN/8  downstream byte enables; 0 for loads and fetches
mem_ready  in  1  downstream completion pulse
mem_rdata  in  XLEN  downstream read data
protocol_err  out  1  sticky: request while own transaction in flight

Behaviour:
- Reset: state IDLE, both pending slots empty, owner none, RR pointer=I. mem_valid, i_ready, d_ready and protocol_err are 0. mem_addr, mem_wdata and mem_wstrb are 0.
- Capture: a *_valid pulse loads that requester's pending slot (address/data/strobe/kind). A new pulse for an unissued slot overwrites it.
- A *_valid pulse while that requester's transaction is in flight is discarded and sets protocol_err (sticky until reset).
- States:
  - IDLE: if any slot is pending (including one captured this cycle), select a winner, register the mem_* fields and pulse mem_valid for 1 cycle on the next cycle, then go to BUSY_I or BUSY_D. Request at cycle N gives mem_valid at N+1.
  - BUSY_x: wait for mem_ready. mem_valid is held 0.
  - On mem_ready: pulse x_ready in the same cycle with x_rdata=mem_rdata (combinational pass-through) and clear the owner's slot.
  - After mem_ready: if the other slot is pending, issue it with mem_valid at M+1 and stay in BUSY; else go to IDLE.
- Arbitration (default): fixed priority, D over I.
- i_rdata and d_rdata always mirror mem_rdata; only the ready pulses are gated by owner.
- flush:
  - Clears a pending, unissued I slot in the same cycle.
  - If an I transaction is in flight, mark it squashed; its mem_ready still returns the FSM to IDLE/next issue, but i_ready is suppressed.
  - An i_valid in the flush cycle is captured (new-PC fetch).
  - D traffic is never affected by flush.
- mem_ready in IDLE: ignored, no ready pulse.
- Simultaneous mem_ready and new request from the completing requester: slot cleared, then recaptured. That request is legal and issues via the next arbitration.
- Reset mid-transaction: all state cleared; any late mem_ready is ignored (owner none).
- Fence: issued as a D transaction with d_store=0 and mem_wstrb=0; ordering is guaranteed by one-outstanding-at-a-time.

Optional Feature:
- ROUND_ROBIN_EN defined: when both slots are pending at an arbitration point, grant the requester opposite to the last granted one. The pointer updates on every issue.
- Undefined: fixed D-over-I priority, no pointer register.
- Single-requester behaviour and latency are identical in both builds.

Test Plan:
- Fetch only:
  - Stimulus: i_valid with i_addr=0x100 at cycle 2; mem_ready with mem_rdata=0x00000013 at cycle 5.
  - Required response: mem_valid=1, mem_instr=1, mem_addr=0x100 at cycle 3; i_ready=1, i_rdata=0x13 at cycle 5; d_ready stays 0.
- Simultaneous requests:
  - Stimulus: i_valid (0x200) and d_valid store (0x8000, wdata 0xDEADBEEF, wstrb 0xF) at cycle 2; mem_ready at cycle 4.
  - Required response (fixed priority): D issued at cycle 3 with wstrb 0xF; I issued at cycle 5 with mem_addr 0x200; I served second.
  - Required response (ROUND_ROBIN_EN, pointer=D): I issued first instead.
- Flush of pending fetch:
  - Stimulus: D in flight; i_valid 0x300; flush next cycle; then mem_ready.
  - Required response: no I transaction issued; FSM returns to IDLE.
- Flush of in-flight fetch:
  - Stimulus: flush during BUSY_I; later mem_ready.
  - Required response: i_ready stays 0; an i_valid 0x400 captured in the flush cycle issues at the cycle after mem_ready.
- Protocol error:
  - Stimulus: second d_valid during BUSY_D.
  - Required response: protocol_err=1 and stays 1; in-flight request completes unchanged.
- Reset mid-transaction:
  - Stimulus: reset during BUSY_D, then mem_ready the cycle after reset release.
  - Required response: no d_ready pulse; all outputs 0; next i_valid issues normally.
